lighthouse_sync_tx: RTL and testbench
=====================================

LIGHTHOUSE_SYNC_TX -- requirements
Module: lighthouse_sync_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, period counter width.
REQ-002 SHALL have parameter DIV, default 2, tick prescale exponent (one tick every 2^DIV clk).
REQ-003 SHALL have parameter PERIOD, default 1000, nominal ticks per sync period.
REQ-004 SHALL have parameter BASE_WIDTH, default 60, pulse ticks for code 0.
REQ-005 SHALL have parameter STEP_WIDTH, default 10, added pulse ticks per code LSB.
REQ-006 SHALL have parameter DEFAULT_CODE, default 0, code used on underrun.
REQ-007 clk  input  1  clock; reset rst, synchronous, active-high.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 en  input  1  enable pulse generation.
REQ-010 code_in  input  3  {skip,data,axis} code for a future pulse.
REQ-011 code_valid / code_ready  input / output  1 each  code handshake.
REQ-012 phase_adj  input  16  signed tick adjustment for one period.
REQ-013 phase_adj_valid  input  1  phase_adj qualifier.
REQ-014 pulse_out  output  1  sync pulse train (registered).
REQ-015 frame_start  output  1  one-clk strobe at each period start.
REQ-016 underrun  output  1  one-clk strobe when a period starts with no code buffered.
REQ-017 count_out  output  WIDTH  current tick count within period.

Function
REQ-018 Tick SHALL assert in clk cycles where the prescaler (0..2^DIV-1, wrapping) equals 0; the prescaler SHALL run only while en=1 and SHALL be 0 after reset and while en=0.
REQ-019 States SHALL be IDLE, PULSE, GAP; reset state IDLE.
REQ-020 IDLE: pulse_out=0, count=0; on the first tick with en=1, SHALL start a period.
REQ-021 Period start SHALL: set count=0, load code (buffer if full, else DEFAULT_CODE with underrun=1), compute width=BASE_WIDTH+STEP_WIDTH*code, compute length=PERIOD+clamped adj, clear adj, pulse frame_start, enter PULSE.
REQ-022 count SHALL increment by 1 per tick; pulse_out SHALL be 1 exactly while in PULSE (count < width), giving width ticks high.
REQ-023 PULSE->GAP at the tick where count reaches width-1; GAP: at the tick where count = length-1, SHALL start a new period (no idle ticks between periods).
REQ-024 Code buffer: one entry; code_ready = buffer empty; accept on code_valid&&code_ready; a period start empties it in the same cycle, and code_ready SHALL not rise before the following cycle.
REQ-025 phase_adj SHALL be clamped to [-PERIOD/4, +PERIOD/4]; latest valid value overwrites; value captured in a period-start cycle applies to the following period, not the one starting.
REQ-026 en falling SHALL return to IDLE at the next clk, pulse_out=0, buffer and adj retained.
REQ-027 Arithmetic SHALL be signed WIDTH bits; length SHALL never go below BASE_WIDTH+7*STEP_WIDTH+1 (guaranteed by parameter check, REQ-031).

Reset
REQ-028 rst SHALL force IDLE, count=0, prescaler=0, pulse_out=0, frame_start=0, underrun=0, code buffer empty (code_ready=1), adj=0, taking precedence over all inputs, including mid-pulse.

Structure
REQ-029 Shared package SHALL hold state enum, 3-bit code type and code field bit positions (skip=2, data=1, axis=0).
REQ-030 Prescaler SHALL be sub-module tick_divider (params DIV; ports clk, rst, en, tick).
REQ-031 Elaboration SHALL fail if PERIOD-PERIOD/4 <= BASE_WIDTH+7*STEP_WIDTH.

Verification (DIV=0, PERIOD=1000, BASE_WIDTH=60, STEP_WIDTH=10 unless stated)
REQ-032 en=1, no codes -> pulse_out high 60 clk every 1000 clk, frame_start and underrun every 1000 clk.
REQ-033 push code 5 during period N -> period N+1 pulse 110 clk; code_ready low from accept to period N+1 start.
REQ-034 phase_adj=+20 mid-period -> next period 1020 clk, following period 1000 clk; adj applied once.
REQ-035 phase_adj=-400 -> clamped, next period 750 clk; phase_adj_valid in a frame_start cycle -> applies one period later.
REQ-036 rst asserted at pulse tick 30 -> next clk pulse_out=0, count_out=0, code_ready=1; release with en=1 -> new pulse starts within one clk.
REQ-037 DIV=2, code 7 -> period 4000 clk, pulse 520 clk, count_out steps every 4 clk.

Source files
------------

// File: rtl/lighthouse_sync_tx_pkg.sv
// Shared types for the lighthouse sync pulse transmitter: FSM states,
// the 3-bit {skip,data,axis} pulse code and its field positions.
package lighthouse_sync_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef logic [2:0] code_t;

  localparam int CODE_SKIP_BIT = 2;
  localparam int CODE_DATA_BIT = 1;
  localparam int CODE_AXIS_BIT = 0;
  localparam int CODE_MAX      = 7;

  // Number of STEP_WIDTH increments a code adds to the base pulse width.
  function automatic int unsigned code_weight(input code_t code);
    return {29'd0, code[CODE_SKIP_BIT], code[CODE_DATA_BIT], code[CODE_AXIS_BIT]};
  endfunction

endpackage

// File: rtl/lighthouse_sync_tx_tick_divider.sv
// Tick prescaler: one tick every 2^DIV enabled clocks. The counter is
// parked at zero while disabled so the first enabled clock always ticks.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // DIV=0 still gets a one-bit register that simply stays at zero.
  localparam int PW = (DIV > 0) ? DIV : 1;

  logic [PW-1:0] presc_q;

  // Wrapping prescaler, held at zero when disabled or when no division is needed.
  always_ff @(posedge clk) begin
    if (rst || !en || (DIV == 0)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign tick = en && (presc_q == '0);

endmodule

// File: rtl/lighthouse_sync_tx.sv
// Lighthouse sync pulse transmitter. Each period emits one pulse whose
// width encodes a 3-bit code; the period length can be trimmed once by
// a clamped signed phase adjustment. Codes arrive through a one-entry
// buffer; an empty buffer at period start falls back to DEFAULT_CODE.
module lighthouse_sync_tx
  import lighthouse_sync_tx_pkg::*;
#(
  parameter int    WIDTH        = 32,
  parameter int    DIV          = 2,
  parameter int    PERIOD       = 1000,
  parameter int    BASE_WIDTH   = 60,
  parameter int    STEP_WIDTH   = 10,
  parameter code_t DEFAULT_CODE = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [15:0]      phase_adj,
  input  logic             phase_adj_valid,
  output logic             pulse_out,
  output logic             frame_start,
  output logic             underrun,
  output logic [WIDTH-1:0] count_out
);

  // The shortest adjusted period must still leave a gap after the widest pulse.
  generate
    if (PERIOD - PERIOD / 4 <= BASE_WIDTH + CODE_MAX * STEP_WIDTH) begin : g_bad_period
      $error("lighthouse_sync_tx: PERIOD too short for widest pulse plus adjustment");
    end
    if (WIDTH < 16) begin : g_bad_width
      $error("lighthouse_sync_tx: WIDTH must hold the 16-bit phase adjustment");
    end
  endgenerate

  localparam logic [WIDTH-1:0]        ONE      = WIDTH'(1);
  localparam logic signed [WIDTH-1:0] ADJ_MAX  = WIDTH'(PERIOD / 4);
  localparam logic signed [WIDTH-1:0] ADJ_MIN  = -ADJ_MAX;
  localparam logic signed [WIDTH-1:0] PERIOD_S = WIDTH'(PERIOD);
  localparam logic signed [WIDTH-1:0] BASE_S   = WIDTH'(BASE_WIDTH);
  localparam logic signed [WIDTH-1:0] STEP_S   = WIDTH'(STEP_WIDTH);

  state_e                   state_q;
  logic [WIDTH-1:0]         count_q;
  logic [WIDTH-1:0]         width_q;
  logic [WIDTH-1:0]         length_q;
  logic                     pulse_q;
  logic                     frame_q;
  logic                     underrun_q;
  logic                     buf_valid_q;
  code_t                    buf_code_q;
  logic signed [WIDTH-1:0]  adj_q;

  logic                     tick;
  logic                     start_period;
  code_t                    load_code;
  logic signed [15:0]       adj_in;
  logic signed [WIDTH-1:0]  adj_ext;
  logic signed [WIDTH-1:0]  adj_clamped_d;
  logic signed [WIDTH-1:0]  width_d;
  logic signed [WIDTH-1:0]  length_d;

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // A period starts on the first tick out of IDLE, or on the last tick of the gap.
  assign start_period = tick &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_GAP) && (count_q == length_q - ONE)));

  assign load_code     = buf_valid_q ? buf_code_q : DEFAULT_CODE;
  assign width_d       = BASE_S + STEP_S * $signed(WIDTH'(code_weight(load_code)));
  assign length_d      = PERIOD_S + adj_q;

  assign adj_in        = phase_adj;
  assign adj_ext       = WIDTH'(adj_in);
  assign adj_clamped_d = (adj_ext > ADJ_MAX) ? ADJ_MAX :
                         (adj_ext < ADJ_MIN) ? ADJ_MIN : adj_ext;

  // Pulse FSM: IDLE until enabled, PULSE for width ticks, GAP until length ticks elapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      width_q    <= '0;
      length_q   <= '0;
      pulse_q    <= 1'b0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
      if (!en) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        pulse_q <= 1'b0;
      end else if (start_period) begin
        state_q    <= ST_PULSE;
        count_q    <= '0;
        pulse_q    <= 1'b1;
        frame_q    <= 1'b1;
        underrun_q <= !buf_valid_q;
        width_q    <= width_d;
        length_q   <= length_d;
      end else if (tick) begin
        case (state_q)
          ST_PULSE: begin
            count_q <= count_q + ONE;
            if (count_q == width_q - ONE) begin
              state_q <= ST_GAP;
              pulse_q <= 1'b0;
            end
          end
          ST_GAP: begin
            count_q <= count_q + ONE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Code buffer and pending phase adjustment; both are consumed at period start.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_code_q  <= '0;
      adj_q       <= '0;
    end else begin
      // An accept can only coincide with a start when the buffer was already empty.
      if (code_valid && code_ready) begin
        buf_valid_q <= 1'b1;
        buf_code_q  <= code_in;
      end else if (start_period) begin
        buf_valid_q <= 1'b0;
      end
      // A value captured in the start cycle survives the clear and serves the next period.
      if (phase_adj_valid) begin
        adj_q <= adj_clamped_d;
      end else if (start_period) begin
        adj_q <= '0;
      end
    end
  end

  assign code_ready  = !buf_valid_q;
  assign pulse_out   = pulse_q;
  assign frame_start = frame_q;
  assign underrun    = underrun_q;
  assign count_out   = count_q;

endmodule

// File: tb/tb_lighthouse_sync_tx.sv
`timescale 1ns/1ps
module tb_lighthouse_sync_tx;

  localparam int PERIOD = 1000;
  localparam int BASE   = 60;
  localparam int STEP   = 10;
  localparam int QTR    = PERIOD / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, code_valid, phase_adj_valid;
  logic [2:0]  code_in;
  logic [15:0] phase_adj;
  logic        code_ready, pulse_out, frame_start, underrun;
  logic [31:0] count_out;

  logic        en2, code_valid2;
  logic [2:0]  code_in2;
  logic        code_ready2, pulse_out2, frame_start2, underrun2;
  logic [31:0] count_out2;

  int checks = 0;
  int errors = 0;

  // reference model: pending code / adjustment and the current period's expectation
  bit m_buf_valid;
  int m_buf_code;
  int m_adj;
  int exp_width, exp_len;
  bit exp_underrun;

  always #5 clk = ~clk;

  lighthouse_sync_tx #(
    .WIDTH(32), .DIV(0), .PERIOD(PERIOD), .BASE_WIDTH(BASE), .STEP_WIDTH(STEP), .DEFAULT_CODE(3'd0)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .phase_adj(phase_adj), .phase_adj_valid(phase_adj_valid),
    .pulse_out(pulse_out), .frame_start(frame_start), .underrun(underrun), .count_out(count_out)
  );

  lighthouse_sync_tx #(
    .WIDTH(32), .DIV(2), .PERIOD(PERIOD), .BASE_WIDTH(BASE), .STEP_WIDTH(STEP), .DEFAULT_CODE(3'd0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .code_in(code_in2), .code_valid(code_valid2),
    .code_ready(code_ready2), .phase_adj(16'd0), .phase_adj_valid(1'b0),
    .pulse_out(pulse_out2), .frame_start(frame_start2), .underrun(underrun2), .count_out(count_out2)
  );

  function automatic int clamp_adj(input int v);
    if (v > QTR) return QTR;
    if (v < -QTR) return -QTR;
    return v;
  endfunction

  task automatic model_reset();
    m_buf_valid = 1'b0;
    m_buf_code  = 0;
    m_adj       = 0;
  endtask

  task automatic model_start();
    exp_underrun = !m_buf_valid;
    exp_width    = BASE + STEP * (m_buf_valid ? m_buf_code : 0);
    exp_len      = PERIOD + m_adj;
    m_buf_valid  = 1'b0;
    m_adj        = 0;
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Called at the negedge where frame_start is high; runs the whole period,
  // optionally pushing a code and/or an adjustment (adj_idx<0 = start cycle).
  task automatic observe_period(input bit do_push, input int push_code, input int push_idx,
                                input bit do_adj, input int adj_val, input int adj_idx,
                                input string name);
    int  highs = 0;
    int  len = -1;
    int  cur_w = exp_width;
    int  cur_l = exp_len;
    int  a_idx = (adj_idx < 0) ? exp_len - 1 : adj_idx;
    bit  ready_last = 1'b1;
    bit  late_adj = 1'b0;
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_start: got %b want 1", name, code_ready);
    end
    for (int i = 0; i < 5000; i++) begin
      if (i > 0 && frame_start === 1'b1) begin
        len = i;
        break;
      end
      if (pulse_out === 1'b1) highs++;
      if (i == 5) begin
        checks++;
        if (count_out !== 32'd5) begin
          errors++;
          $display("FAIL %s count_out: got %0d want 5", name, count_out);
        end
      end
      code_valid      = do_push && (i == push_idx);
      code_in         = push_code[2:0];
      phase_adj_valid = do_adj && (i == a_idx);
      phase_adj       = adj_val[15:0];
      if (do_push && i == push_idx && !m_buf_valid) begin
        m_buf_valid = 1'b1;
        m_buf_code  = push_code;
      end
      if (do_adj && i == a_idx) begin
        if (i == cur_l - 1) late_adj = 1'b1;
        else m_adj = clamp_adj(adj_val);
      end
      ready_last = code_ready;
      @(negedge clk);
    end
    code_valid      = 1'b0;
    phase_adj_valid = 1'b0;
    if (len < 0) begin
      errors++;
      $display("FAIL %s timeout: no frame_start within 5000 clk, want period %0d", name, cur_l);
      finish_sim();
    end
    checks++;
    if (highs != cur_w) begin
      errors++;
      $display("FAIL %s pulse_width: got %0d want %0d", name, highs, cur_w);
    end
    checks++;
    if (len != cur_l) begin
      errors++;
      $display("FAIL %s period_len: got %0d want %0d", name, len, cur_l);
    end
    if (do_push) begin
      checks++;
      if (ready_last !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_before_start: got %b want 0", name, ready_last);
      end
    end
    model_start();
    if (late_adj) m_adj = clamp_adj(adj_val);
    checks++;
    if (underrun !== exp_underrun) begin
      errors++;
      $display("FAIL %s underrun: got %b want %b", name, underrun, exp_underrun);
    end
    $display("period %-14s width=%0d len=%0d next_width=%0d next_len=%0d", name, highs, len, exp_width, exp_len);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    code_valid = 1'b0; code_in = 3'd0; phase_adj_valid = 1'b0; phase_adj = 16'd0;
    code_valid2 = 1'b0; code_in2 = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pulse_out, frame_start, underrun, code_ready} !== 4'b0001 || count_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got pulse=%b frame=%b underrun=%b ready=%b count=%0d want 0 0 0 1 0",
               pulse_out, frame_start, underrun, code_ready, count_out);
    end
    checks++;
    if ({pulse_out2, code_ready2} !== 2'b01 || count_out2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state2: got pulse=%b ready=%b count=%0d want 0 1 0", pulse_out2, code_ready2, count_out2);
    end
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_disabled: got frame=%b pulse=%b want 0 0", frame_start, pulse_out);
    end
    $display("reset done");
  endtask

  task automatic test_no_codes();
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || pulse_out !== 1'b1) begin
      errors++;
      $display("FAIL first_start: got frame=%b pulse=%b want 1 1", frame_start, pulse_out);
    end
    model_start();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL first_underrun: got %b want 1", underrun);
    end
    observe_period(0, 0, 0, 0, 0, 0, "no_codes_a");
    observe_period(0, 0, 0, 0, 0, 0, "no_codes_b");
  endtask

  task automatic test_code_push();
    observe_period(1, 5, 10, 0, 0, 0, "push5");
    observe_period(0, 0, 0, 0, 0, 0, "code5_used");
    observe_period(0, 0, 0, 0, 0, 0, "after_code5");
  endtask

  task automatic test_phase_adj();
    observe_period(0, 0, 0, 1, 20, 300, "adj_p20");
    observe_period(0, 0, 0, 0, 0, 0, "adj_applied");
    observe_period(0, 0, 0, 0, 0, 0, "adj_once");
  endtask

  task automatic test_adj_clamp_and_start();
    observe_period(0, 0, 0, 1, -400, 50, "adj_m400");
    observe_period(0, 0, 0, 0, 0, 0, "clamped_750");
    observe_period(0, 0, 0, 1, 30, -1, "adj_at_start");
    observe_period(0, 0, 0, 0, 0, 0, "start_unaff");
    observe_period(0, 0, 0, 0, 0, 0, "late_applied");
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      bit do_push = $urandom_range(0, 1) == 1;
      int code    = $urandom_range(0, 7);
      int pidx    = $urandom_range(0, 600);
      bit do_adj  = $urandom_range(0, 1) == 1;
      int aval    = int'($urandom_range(0, 1200)) - 600;
      int aidx    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 700));
      observe_period(do_push, code, pidx, do_adj, aval, aidx, "random");
    end
    observe_period(0, 0, 0, 0, 0, 0, "random_drain");
  endtask

  task automatic test_en_drop();
    code_valid = 1'b1; code_in = 3'd3;
    m_buf_valid = 1'b1; m_buf_code = 3;
    @(negedge clk);
    code_valid = 1'b0;
    phase_adj_valid = 1'b1; phase_adj = 16'd40;
    m_adj = 40;
    @(negedge clk);
    phase_adj_valid = 1'b0;
    repeat (18) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (pulse_out !== 1'b0 || count_out !== 32'd0) begin
      errors++;
      $display("FAIL en_drop_idle: got pulse=%b count=%0d want 0 0", pulse_out, count_out);
    end
    checks++;
    if (code_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_buffer_kept: got ready=%b want 0", code_ready);
    end
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL en_restart: got frame=%b want 1", frame_start);
    end
    model_start();
    checks++;
    if (underrun !== exp_underrun) begin
      errors++;
      $display("FAIL en_restart_underrun: got %b want %b", underrun, exp_underrun);
    end
    $display("en dropped and restored, expect width=%0d len=%0d", exp_width, exp_len);
    observe_period(0, 0, 0, 0, 0, 0, "after_en_drop");
  endtask

  task automatic test_reset_mid_pulse();
    repeat (5) @(negedge clk);
    code_valid = 1'b1; code_in = 3'd6;
    @(negedge clk);
    code_valid = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pulse_out !== 1'b0 || count_out !== 32'd0 || code_ready !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got pulse=%b count=%0d ready=%b frame=%b want 0 0 1 0",
               pulse_out, count_out, code_ready, frame_start);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || pulse_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_start: got frame=%b pulse=%b want 1 1", frame_start, pulse_out);
    end
    model_start();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_underrun: got %b want 1", underrun);
    end
    $display("reset mid-pulse recovered");
    observe_period(0, 0, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_div2();
    int want_hi[2];
    bit want_ur[2];
    bit seen = 1'b0;
    en = 1'b0;
    want_hi[0] = 4 * BASE;
    want_hi[1] = 4 * (BASE + 7 * STEP);
    want_ur[0] = 1'b1;
    want_ur[1] = 1'b0;
    en2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_start2 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL div2_first_start: got no frame_start want one within 10 clk");
      finish_sim();
    end
    for (int p = 0; p < 2; p++) begin
      int highs = 0;
      int len = -1;
      checks++;
      if (underrun2 !== want_ur[p]) begin
        errors++;
        $display("FAIL div2_underrun_%0d: got %b want %b", p, underrun2, want_ur[p]);
      end
      for (int i = 0; i < 5000; i++) begin
        if (i > 0 && frame_start2 === 1'b1) begin
          len = i;
          break;
        end
        if (pulse_out2 === 1'b1) highs++;
        if (i == 9) begin
          checks++;
          if (count_out2 !== 32'd2) begin
            errors++;
            $display("FAIL div2_count_step: got %0d want 2", count_out2);
          end
        end
        code_valid2 = (p == 0) && (i == 0);
        code_in2    = 3'd7;
        @(negedge clk);
      end
      code_valid2 = 1'b0;
      checks++;
      if (highs != want_hi[p]) begin
        errors++;
        $display("FAIL div2_pulse_%0d: got %0d want %0d", p, highs, want_hi[p]);
      end
      checks++;
      if (len != 4 * PERIOD) begin
        errors++;
        $display("FAIL div2_period_%0d: got %0d want %0d", p, len, 4 * PERIOD);
      end
      $display("div2 period %0d width_clk=%0d len_clk=%0d", p, highs, len);
      if (len < 0) finish_sim();
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_codes();
    test_code_push();
    test_phase_adj();
    test_adj_clamp_and_start();
    test_random();
    test_en_drop();
    test_reset_mid_pulse();
    test_div2();
    finish_sim();
  end

endmodule
